controle_multiciclo: RTL
========================

Name: controle_multiciclo

Overview:
- Multicycle control unit that drives the UP datapath control inputs (PCwrite, IRwrite, AluOperation, MemRead, exitState and the remaining strobes and mux selects).
- Reads opcode/funct fields from the instruction register and the ALU zero flag. Sequences fetch, decode, execute, memory and writeback for a RISC-V subset.
- Sits beside UP and replaces hand-driven control in the simulacao-level benches.

Parameters:
- MEM_LAT, 1, Memoria32 read latency in cycles; sets the number of FETCH_WAIT/MEM_WAIT cycles (1 or 2).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b30  in  1  IR[30]
- zero  in  1  ALU zero flag, combinational from datapath
- PCwrite  out  1  PC register load
- IRwrite  out  1  instruction register load
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write (Wr)
- IorD  out  1  memory address select: 0 = PC, 1 = AluOut
- LoadA, LoadB  out  1 each  register-file output latches
- LoadAluOut  out  1  AluOut register load
- LoadMDR  out  1  memory data register load
- RegWrite  out  1  register-file write
- MemToReg  out  1  writeback select: 0 = AluOut, 1 = MDR
- AluSrcA  out  1  0 = PC, 1 = A
- AluSrcB  out  2  00 = B, 01 = const 4, 10 = imm, 11 = imm<<1
- PCSource  out  1  0 = ALU result, 1 = AluOut
- AluOperation  out  3  000 LOAD, 001 ADD, 010 SUB, 011 AND, 100 INC, 101 NOT, 110 XOR, 111 CMP
- exitState  out  4  current state code, for debug/bench

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to RESET (0) immediately.
  - All strobes are 0; selects and AluOperation are 0.
  - Reset asserted mid-instruction aborts the instruction; no partial write strobe may appear after rst falls.
- State codes: RESET 0, FETCH 1, FETCH_WAIT 2, DECODE 3, EXEC_R 4, EXEC_I 5, ADDR 6, MEM_RD 7, MEM_WAIT 8, WB_LD 9, MEM_WR 10, BRANCH 11, WB_ALU 12, ERROR 15.
- Outputs are Moore (registered state, decoded combinationally). The only exception is PCwrite in BRANCH, which is Mealy on zero and funct3.
- RESET: goes to FETCH on the first clock after rst = 1.
- FETCH: MemRead = 1, IorD = 0, AluSrcA = 0, AluSrcB = 01, ADD. Next state FETCH_WAIT.
- FETCH_WAIT:
  - Held for MEM_LAT cycles; MemRead = 1 throughout.
  - Last cycle only: IRwrite = 1, PCwrite = 1, PCSource = 0, ADD of PC + 4. PC and IR update on the same edge.
  - Next state DECODE.
- DECODE: LoadA = 1, LoadB = 1, LoadAluOut = 1, AluSrcA = 0, AluSrcB = 11, ADD (branch target). Next state by opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011, 0100011 → ADDR
  - 1100011 → BRANCH
  - anything else → ERROR
- EXEC_R: AluSrcA = 1, AluSrcB = 00, LoadAluOut = 1. ALU op by funct3/funct7b30:
  - 000/0 → ADD; 000/1 → SUB
  - 111 → AND; 100 → XOR
  - Next state WB_ALU. Any other funct3 → ERROR, with LoadAluOut suppressed.
- EXEC_I: same as EXEC_R but AluSrcB = 10 and funct7b30 ignored; funct3 000 ADD, 111 AND, 100 XOR. Next state WB_ALU; any other funct3 → ERROR.
- WB_ALU: RegWrite = 1, MemToReg = 0. Next state FETCH.
- ADDR: AluSrcA = 1, AluSrcB = 10, ADD, LoadAluOut = 1. Next state MEM_RD if opcode = 0000011, else MEM_WR.
- MEM_RD: MemRead = 1, IorD = 1. Next state MEM_WAIT.
- MEM_WAIT: held for MEM_LAT cycles; MemRead = 1, IorD = 1. LoadMDR = 1 on the last cycle. Next state WB_LD.
- WB_LD: RegWrite = 1, MemToReg = 1. Next state FETCH.
- MEM_WR: MemWrite = 1, IorD = 1 for exactly one cycle. Next state FETCH.
- BRANCH:
  - AluSrcA = 1, AluSrcB = 00, SUB, PCSource = 1.
  - PCwrite = (funct3 = 000 & zero) | (funct3 = 001 & !zero).
  - Next state FETCH. Any other funct3 → ERROR with PCwrite = 0.
- ERROR: sticky until reset; all strobes 0; exitState = 15.
- Latency at MEM_LAT = 1, counted FETCH to the next FETCH:
  - R/I: 5 cycles
  - load: 7 cycles
  - store: 5 cycles
  - branch: 4 cycles
- Each extra MEM_LAT cycle adds 1 to every FETCH_WAIT and MEM_WAIT.
- Per-cycle invariants: at most one of MemWrite/RegWrite/IRwrite high; MemRead and MemWrite never both high.
- Opcode/funct inputs are sampled only in DECODE and later, never during FETCH/FETCH_WAIT.

Test Plan:
- rst = 0 for 1 period, then 1 → exitState 0 during reset, 1 on the first edge after release, 2 on the next; all strobes 0 while rst = 0.
- opcode 0110011, funct3 000, funct7b30 1 → states 1,2,3,4,12,1. AluOperation = 010 in EXEC_R; RegWrite = 1 for exactly 1 cycle.
- opcode 0000011 (load), MEM_LAT = 1 → states 1,2,3,6,7,8,9,1. LoadMDR = 1 only in state 8; MemToReg = 1 in state 9.
- opcode 1100011 with funct3 000: zero = 1 → PCwrite = 1, PCSource = 1 in state 11; zero = 0 → PCwrite = 0. With funct3 001 the results invert.
- opcode 1111111 → DECODE then ERROR (15) held for 20 cycles with no strobes; rst = 0 returns to state 0.
- rst dropped to 0 mid-cycle while in state 10 → MemWrite falls at once (asynchronously), exitState = 0. After release the FSM restarts with FETCH.

Source files
------------

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle control unit for the UP RISC-V datapath.
// The state register sits in a single always_ff block. Outputs are decoded
// combinationally from that state (Moore). The one exception is PCwrite in
// BRANCH, which also depends on zero and funct3 (Mealy).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   opcode/funct3/  instruction fields from IR; sampled from DECODE onward
//   funct7b30
//   zero            ALU zero flag (combinational from datapath)
//   PCwrite..LoadMDR, RegWrite, MemToReg   datapath strobes
//   AluSrcA/AluSrcB/PCSource/IorD          datapath mux selects
//   AluOperation    ALU function code
//   exitState       current state code (debug)
module controle_multiciclo #(
   parameter int MEM_LAT = 1   // memory read latency, 1 or 2 cycles
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b30,
   input  logic       zero,
   output logic       PCwrite,
   output logic       IRwrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       LoadA,
   output logic       LoadB,
   output logic       LoadAluOut,
   output logic       LoadMDR,
   output logic       RegWrite,
   output logic       MemToReg,
   output logic       AluSrcA,
   output logic [1:0] AluSrcB,
   output logic       PCSource,
   output logic [2:0] AluOperation,
   output logic [3:0] exitState
);

   typedef enum logic [3:0] {
      S_RESET      = 4'd0,
      S_FETCH      = 4'd1,
      S_FETCH_WAIT = 4'd2,
      S_DECODE     = 4'd3,
      S_EXEC_R     = 4'd4,
      S_EXEC_I     = 4'd5,
      S_ADDR       = 4'd6,
      S_MEM_RD     = 4'd7,
      S_MEM_WAIT   = 4'd8,
      S_WB_LD      = 4'd9,
      S_MEM_WR     = 4'd10,
      S_BRANCH     = 4'd11,
      S_WB_ALU     = 4'd12,
      S_ERROR      = 4'd15
   } state_t;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [2:0] ALU_LOAD = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_AND  = 3'b011;
   localparam logic [2:0] ALU_XOR  = 3'b110;

   // Index of the final wait cycle in FETCH_WAIT / MEM_WAIT.
   localparam logic [1:0] LAST_WAIT = 2'(MEM_LAT - 1);

   state_t     state;
   logic [1:0] wait_cnt;
   logic       last_wait;
   logic [2:0] fn_op;
   logic       fn_ok;
   logic       br_ok;
   logic       br_take;

   assign last_wait = (wait_cnt == LAST_WAIT);

   // ALU function for EXEC_R / EXEC_I. funct7b30 selects SUB only for R-type.
   always_comb begin
      fn_op = ALU_LOAD;
      fn_ok = 1'b1;
      case (funct3)
         3'b000:  fn_op = (state == S_EXEC_R && funct7b30) ? ALU_SUB : ALU_ADD;
         3'b111:  fn_op = ALU_AND;
         3'b100:  fn_op = ALU_XOR;
         default: fn_ok = 1'b0;
      endcase
   end

   // BEQ (000) is taken on zero, BNE (001) on !zero.
   assign br_ok   = (funct3 == 3'b000) || (funct3 == 3'b001);
   assign br_take = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_RESET;
         wait_cnt <= 2'd0;
      end else begin
         case (state)
            S_RESET:  state <= S_FETCH;
            S_FETCH: begin
               state    <= S_FETCH_WAIT;
               wait_cnt <= 2'd0;
            end
            S_FETCH_WAIT: begin
               if (last_wait) state <= S_DECODE;
               else           wait_cnt <= wait_cnt + 2'd1;
            end
            S_DECODE: begin
               case (opcode)
                  OP_R:         state <= S_EXEC_R;
                  OP_I:         state <= S_EXEC_I;
                  OP_LD, OP_ST: state <= S_ADDR;
                  OP_BR:        state <= S_BRANCH;
                  default:      state <= S_ERROR;
               endcase
            end
            S_EXEC_R, S_EXEC_I: state <= fn_ok ? S_WB_ALU : S_ERROR;
            S_ADDR:   state <= (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
               state    <= S_MEM_WAIT;
               wait_cnt <= 2'd0;
            end
            S_MEM_WAIT: begin
               if (last_wait) state <= S_WB_LD;
               else           wait_cnt <= wait_cnt + 2'd1;
            end
            S_WB_LD, S_WB_ALU, S_MEM_WR: state <= S_FETCH;
            S_BRANCH: state <= br_ok ? S_FETCH : S_ERROR;
            S_ERROR:  state <= S_ERROR;
            default:  state <= S_ERROR;   // unused codes 13/14
         endcase
      end
   end

   // Output decode. RESET/ERROR fall through to the all-zero defaults, so an
   // asynchronous reset kills any write strobe immediately.
   always_comb begin
      PCwrite      = 1'b0;
      IRwrite      = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IorD         = 1'b0;
      LoadA        = 1'b0;
      LoadB        = 1'b0;
      LoadAluOut   = 1'b0;
      LoadMDR      = 1'b0;
      RegWrite     = 1'b0;
      MemToReg     = 1'b0;
      AluSrcA      = 1'b0;
      AluSrcB      = 2'b00;
      PCSource     = 1'b0;
      AluOperation = ALU_LOAD;
      case (state)
         S_FETCH: begin
            MemRead      = 1'b1;
            AluSrcB      = 2'b01;
            AluOperation = ALU_ADD;
         end
         S_FETCH_WAIT: begin
            MemRead = 1'b1;
            if (last_wait) begin
               // PC <= PC + 4 and IR load share this edge
               IRwrite      = 1'b1;
               PCwrite      = 1'b1;
               AluSrcB      = 2'b01;
               AluOperation = ALU_ADD;
            end
         end
         S_DECODE: begin
            // Speculatively compute the branch target into AluOut.
            LoadA        = 1'b1;
            LoadB        = 1'b1;
            LoadAluOut   = 1'b1;
            AluSrcB      = 2'b11;
            AluOperation = ALU_ADD;
         end
         S_EXEC_R, S_EXEC_I: begin
            AluSrcA = 1'b1;
            AluSrcB = (state == S_EXEC_I) ? 2'b10 : 2'b00;
            if (fn_ok) begin
               LoadAluOut   = 1'b1;
               AluOperation = fn_op;
            end
         end
         S_ADDR: begin
            AluSrcA      = 1'b1;
            AluSrcB      = 2'b10;
            AluOperation = ALU_ADD;
            LoadAluOut   = 1'b1;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEM_WAIT: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            LoadMDR = last_wait;
         end
         S_WB_LD: begin
            RegWrite = 1'b1;
            MemToReg = 1'b1;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_BRANCH: begin
            AluSrcA      = 1'b1;
            AluOperation = ALU_SUB;
            PCSource     = 1'b1;
            PCwrite      = br_ok & br_take;
         end
         S_WB_ALU: RegWrite = 1'b1;
         default: ;
      endcase
   end

   assign exitState = state;

endmodule
